// File: rtl/branch_npc.sv
// branch_npc: next-fetch-PC generator with delay-slot redirect, a RUN/PEND
// handshake against instruction memory, a sticky jr alignment flag and
// conditional-branch statistics counters.
module branch_npc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        IMemReady,
  input  logic        D_Valid,
  input  logic [1:0]  D_NPCOp,
  input  logic        BranchComp,
  input  logic [31:0] D_PC,
  input  logic [25:0] D_Imm26,
  input  logic [31:0] D_RegA,
  output logic [31:0] F_PC,
  output logic        Pending,
  output logic        AlignErr,
  output logic [31:0] BranchCnt,
  output logic [31:0] TakenCnt
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t             r_state;
  logic [31:0]        r_pend_tgt;

  logic               w_resolve;
  logic               w_take;
  logic               w_is_br;
  logic [31:0]        w_seq_pc;
  logic [31:0]        w_dpc4;
  logic signed [31:0] w_br_off;
  logic [31:0]        w_target;

  // A D instruction resolves once, in the cycle it is valid and not stalled;
  // the delay slot is already at F_PC, so a redirect replaces F_PC+4.
  assign w_resolve = D_Valid && !Stall;
  assign w_is_br   = (D_NPCOp == 2'b01);
  assign w_take    = w_resolve && (D_NPCOp[1] || (w_is_br && BranchComp));
  assign w_seq_pc  = F_PC + 32'd4;
  assign w_dpc4    = D_PC + 32'd4;
  assign w_br_off  = {{14{D_Imm26[15]}}, D_Imm26[15:0], 2'b00};

  // Redirect target selected by the D instruction's next-PC operation
  always_comb begin
    w_target = w_seq_pc;
    case (D_NPCOp)
      2'b01:   w_target = w_dpc4 + $unsigned(w_br_off);
      2'b10:   w_target = {w_dpc4[31:28], D_Imm26, 2'b00};
      2'b11:   w_target = {D_RegA[31:2], 2'b00};
      default: w_target = w_seq_pc;
    endcase
  end

  // Fetch-PC FSM: a redirect that memory cannot accept yet is parked in PEND
  always_ff @(posedge clk) begin
    if (reset) begin
      F_PC       <= RESET_PC;
      r_state    <= RUN;
      Pending    <= 1'b0;
      r_pend_tgt <= 32'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (!Stall && IMemReady) begin
            F_PC <= w_take ? w_target : w_seq_pc;
          end else if (w_take) begin
            r_pend_tgt <= w_target;
            r_state    <= PEND;
            Pending    <= 1'b1;
          end
        end
        PEND: begin
          if (!Stall && IMemReady) begin
            F_PC    <= r_pend_tgt;
            r_state <= RUN;
            Pending <= 1'b0;
          end
        end
      endcase
    end
  end

  // Branch statistics and sticky jr misalignment flag, independent of memory
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCnt <= 32'd0;
      TakenCnt  <= 32'd0;
      AlignErr  <= 1'b0;
    end else begin
      if (w_resolve && w_is_br) begin
        BranchCnt <= BranchCnt + 32'd1;
        if (BranchComp) TakenCnt <= TakenCnt + 32'd1;
      end
      if (w_resolve && (D_NPCOp == 2'b11) && (D_RegA[1:0] != 2'b00))
        AlignErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_npc.sv
// tb_branch_npc: directed scenarios followed by randomized traffic, checked
// every cycle against a behavioural next-PC model.
module tb_branch_npc;

  logic        clk = 1'b0;
  logic        reset, Stall, IMemReady, D_Valid, BranchComp;
  logic [1:0]  D_NPCOp;
  logic [31:0] D_PC, D_RegA;
  logic [25:0] D_Imm26;
  logic [31:0] F_PC, BranchCnt, TakenCnt;
  logic        Pending, AlignErr;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc, m_tgt, m_bc, m_tc;
  logic        m_pend, m_align;

  branch_npc #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .IMemReady(IMemReady),
    .D_Valid(D_Valid), .D_NPCOp(D_NPCOp), .BranchComp(BranchComp),
    .D_PC(D_PC), .D_Imm26(D_Imm26), .D_RegA(D_RegA),
    .F_PC(F_PC), .Pending(Pending), .AlignErr(AlignErr),
    .BranchCnt(BranchCnt), .TakenCnt(TakenCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Target address computed with plain arithmetic from the instruction fields
  function automatic logic [31:0] model_target();
    int signed off;
    case (D_NPCOp)
      2'b01: begin
        off = int'($signed(D_Imm26[15:0])) * 4;
        return D_PC + 32'd4 + 32'(off);
      end
      2'b10: return ((D_PC + 32'd4) & 32'hF000_0000) | (32'(D_Imm26) * 32'd4);
      2'b11: return D_RegA & ~32'd3;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  task automatic model_step();
    bit resolve, take;
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h3000; m_pend = 0; m_tgt = 0; m_align = 0; m_bc = 0; m_tc = 0;
      return;
    end
    resolve = D_Valid && !Stall;
    take    = resolve && (D_NPCOp == 2 || D_NPCOp == 3 || (D_NPCOp == 1 && BranchComp));
    tgt     = model_target();
    if (resolve && D_NPCOp == 1) begin
      m_bc = m_bc + 1;
      if (BranchComp) m_tc = m_tc + 1;
    end
    if (resolve && D_NPCOp == 3 && D_RegA[1:0] != 0) m_align = 1;
    if (m_pend) begin
      if (!Stall && IMemReady) begin m_pc = m_tgt; m_pend = 0; end
    end else if (!Stall) begin
      if (IMemReady) m_pc = take ? tgt : m_pc + 32'd4;
      else if (take) begin m_pend = 1; m_tgt = tgt; end
    end
  endtask

  // Advance one clock and compare all outputs against the model
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".F_PC"},      F_PC,      m_pc);
    check({tag, ".Pending"},   {31'd0, Pending},  {31'd0, m_pend});
    check({tag, ".AlignErr"},  {31'd0, AlignErr}, {31'd0, m_align});
    check({tag, ".BranchCnt"}, BranchCnt, m_bc);
    check({tag, ".TakenCnt"},  TakenCnt,  m_tc);
  endtask

  task automatic idle();
    reset = 0; Stall = 0; IMemReady = 1; D_Valid = 0; D_NPCOp = 0;
    BranchComp = 0; D_PC = 0; D_Imm26 = 0; D_RegA = 0;
  endtask

  task automatic dinst(input logic [1:0] op, input logic comp, input logic [31:0] pc,
                       input logic [25:0] imm, input logic [31:0] rega);
    D_Valid = 1; D_NPCOp = op; BranchComp = comp; D_PC = pc; D_Imm26 = imm; D_RegA = rega;
  endtask

  initial begin
    m_pc = 'x; m_pend = 'x; m_tgt = 'x; m_align = 'x; m_bc = 'x; m_tc = 'x;
    idle();
    reset = 1;
    tick("reset");
    check("reset.F_PC_const", F_PC, 32'h3000);

    // sequential fetch
    idle();
    tick("seq1"); tick("seq2"); tick("seq3");
    check("seq3.F_PC_const", F_PC, 32'h300C);

    // taken backward branch from F_PC=3008
    reset = 1; tick("rst2");
    idle(); tick("pre1"); tick("pre2");
    check("br.start", F_PC, 32'h3008);
    dinst(2'b01, 1'b1, 32'h3004, 26'h000FFFE, 32'd0);
    tick("br_taken");
    check("br_taken.F_PC_const", F_PC, 32'h3000);
    check("br_taken.cnt_const", TakenCnt, 32'd1);

    // not-taken branch held by a 2-cycle stall
    dinst(2'b01, 1'b0, 32'h2FFC, 26'h0000010, 32'd0);
    Stall = 1;
    tick("nt_stall1"); tick("nt_stall2");
    Stall = 0;
    tick("nt_go");
    check("nt_go.F_PC_const", F_PC, 32'h3004);
    check("nt_go.BranchCnt_const", BranchCnt, 32'd2);

    // j while memory busy -> PEND, then accept
    dinst(2'b10, 1'b0, 32'h3010, 26'h0000C10, 32'd0);
    IMemReady = 0;
    tick("j_busy");
    check("j_busy.Pending_const", {31'd0, Pending}, 32'd1);
    // PEND ignores a new take and holds under stall
    dinst(2'b11, 1'b0, 32'h3000, 26'd0, 32'h0000_5000);
    IMemReady = 1; Stall = 1;
    tick("pend_stall");
    Stall = 0;
    D_Valid = 0;
    tick("j_accept");
    check("j_accept.F_PC_const", F_PC, 32'h3040);

    // misaligned jr, sticky flag
    dinst(2'b11, 1'b0, 32'h3040, 26'd0, 32'h0000_3023);
    tick("jr_mis");
    check("jr_mis.F_PC_const", F_PC, 32'h3020);
    idle();
    tick("jr_sticky");
    check("jr_sticky.AlignErr_const", {31'd0, AlignErr}, 32'd1);
    // enter PEND, then reset overrides it
    dinst(2'b11, 1'b0, 32'h3020, 26'd0, 32'h0000_4000);
    IMemReady = 0;
    tick("jr_pend");
    idle(); IMemReady = 0; reset = 1;
    tick("rst_in_pend");
    check("rst_in_pend.F_PC_const", F_PC, 32'h3000);

    // wrap at 2^32 via jr to the last word, and branch target wrap
    idle();
    dinst(2'b11, 1'b0, 32'h3000, 26'd0, 32'hFFFF_FFFC);
    tick("jr_top");
    idle();
    tick("pc_wrap");
    check("pc_wrap.F_PC_const", F_PC, 32'h0000_0000);
    dinst(2'b01, 1'b1, 32'hFFFF_FFF8, 26'h0000010, 32'd0);
    tick("br_wrap");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      Stall      = ($urandom_range(0, 3) == 0);
      IMemReady  = ($urandom_range(0, 2) != 0);
      D_Valid    = ($urandom_range(0, 3) != 0);
      D_NPCOp    = 2'($urandom_range(0, 3));
      BranchComp = 1'($urandom);
      D_PC       = $urandom & ~32'd3;
      D_Imm26    = 26'($urandom);
      D_RegA     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
